// File: rtl/sequence_capture_detector_if.sv
// Bundle of pattern-load and serial-stream signals between the sequence
// detector and its controller; outputs flow back through the same bundle.
interface sequence_capture_detector_if #(
    parameter int WIDTH   = 10,
    parameter int COUNT_W = 8
);
    logic [WIDTH-1:0]   switches;
    logic               load;
    logic               din;
    logic               din_valid;
    logic [WIDTH-1:0]   pattern;
    logic               armed;
    logic               detect;
    logic [COUNT_W-1:0] match_count;

    modport master (
        output switches, load, din, din_valid,
        input  pattern, armed, detect, match_count
    );

    modport slave (
        input  switches, load, din, din_valid,
        output pattern, armed, detect, match_count
    );
endinterface

// File: rtl/sequence_capture_detector.sv
// Latches a WIDTH-bit pattern on load, then pulses detect whenever the last
// WIDTH accepted serial bits (MSB-first) equal it; keeps a saturating hit count.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no pattern loaded since reset; accepted bits are ignored
// FILL    | armed, fewer than WIDTH bits accepted since load/last match
// HUNT    | armed, window full; every accepted bit is compared
module sequence_capture_detector #(
    parameter int WIDTH   = 10,
    parameter int COUNT_W = 8,
    parameter int OVERLAP = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    sequence_capture_detector_if.slave   bus
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("sequence_capture_detector: WIDTH must be in 2..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HUNT = 2'd2
    } state_t;

    state_t             state_q,       state_d;
    logic [WIDTH-1:0]   pattern_q,     pattern_d;
    logic [WIDTH-1:0]   window_q,      window_d;
    logic [FILL_W-1:0]  fill_q,        fill_d;
    logic               armed_q,       armed_d;
    logic               detect_q,      detect_d;
    logic [COUNT_W-1:0] match_count_q, match_count_d;

    logic [WIDTH-1:0]   window_next;
    logic [FILL_W-1:0]  fill_next;
    logic               hit;

    always_comb begin
        state_d       = state_q;
        pattern_d     = pattern_q;
        window_d      = window_q;
        fill_d        = fill_q;
        armed_d       = armed_q;
        detect_d      = 1'b0;
        match_count_d = match_count_q;

        window_next = {window_q[WIDTH-2:0], bus.din};
        fill_next   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
        hit         = 1'b0;

        // Load has priority; a bit presented on the same edge is dropped.
        if (bus.load) begin
            pattern_d = bus.switches;
            window_d  = '0;
            fill_d    = '0;
            armed_d   = 1'b1;
            state_d   = ST_FILL;
        end else if (bus.din_valid && state_q != ST_IDLE) begin
            window_d = window_next;
            fill_d   = fill_next;
            hit      = (fill_next == FILL_FULL) && (window_next == pattern_q);

            if (hit) begin
                detect_d = 1'b1;
                if (match_count_q != '1) begin
                    match_count_d = match_count_q + COUNT_W'(1);
                end
            end

            if (hit && OVERLAP == 0) begin
                // Window keeps its contents, but WIDTH fresh bits are
                // required before the next compare.
                fill_d  = '0;
                state_d = ST_FILL;
            end else if (fill_next == FILL_FULL) begin
                state_d = ST_HUNT;
            end else begin
                state_d = ST_FILL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pattern_q     <= '0;
            window_q      <= '0;
            fill_q        <= '0;
            armed_q       <= 1'b0;
            detect_q      <= 1'b0;
            match_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            window_q      <= window_d;
            fill_q        <= fill_d;
            armed_q       <= armed_d;
            detect_q      <= detect_d;
            match_count_q <= match_count_d;
        end
    end

    assign bus.pattern     = pattern_q;
    assign bus.armed       = armed_q;
    assign bus.detect      = detect_q;
    assign bus.match_count = match_count_q;

endmodule

// File: tb/tb_sequence_capture_detector.sv
// Directed bench for sequence_capture_detector: four instances cover the
// default 10-bit configuration, 4-bit overlap / non-overlap and 2-bit saturation.
module tb_sequence_capture_detector;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;

    always #5 clk_sys = ~clk_sys;

    sequence_capture_detector_if #(.WIDTH(10), .COUNT_W(8)) b10 ();
    sequence_capture_detector_if #(.WIDTH(4),  .COUNT_W(8)) b4o ();
    sequence_capture_detector_if #(.WIDTH(4),  .COUNT_W(8)) b4n ();
    sequence_capture_detector_if #(.WIDTH(2),  .COUNT_W(2)) b2  ();

    sequence_capture_detector #(.WIDTH(10), .COUNT_W(8), .OVERLAP(1)) u_w10 (
        .clk(clk_sys), .rst(rst), .bus(b10));
    sequence_capture_detector #(.WIDTH(4), .COUNT_W(8), .OVERLAP(1)) u_w4o (
        .clk(clk_sys), .rst(rst), .bus(b4o));
    sequence_capture_detector #(.WIDTH(4), .COUNT_W(8), .OVERLAP(0)) u_w4n (
        .clk(clk_sys), .rst(rst), .bus(b4n));
    sequence_capture_detector #(.WIDTH(2), .COUNT_W(2), .OVERLAP(1)) u_w2 (
        .clk(clk_sys), .rst(rst), .bus(b2));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic load10(input logic [9:0] sw);
        b10.switches = sw;
        b10.load     = 1'b1;
        tick();
        b10.load     = 1'b0;
    endtask

    task automatic bit10(input logic b, input logic exp_det, input string tag);
        b10.din       = b;
        b10.din_valid = 1'b1;
        tick();
        b10.din_valid = 1'b0;
        check_val(tag, 32'(b10.detect), 32'(exp_det));
    endtask

    logic [9:0] p1;
    logic [9:0] p2;
    logic [7:0] s4;

    initial begin
        p1 = 10'b1011101101;
        p2 = 10'b0100001000;
        s4 = 8'b10101010;
        b10.switches = '0; b10.load = 0; b10.din = 0; b10.din_valid = 0;
        b4o.switches = '0; b4o.load = 0; b4o.din = 0; b4o.din_valid = 0;
        b4n.switches = '0; b4n.load = 0; b4n.din = 0; b4n.din_valid = 0;
        b2.switches  = '0; b2.load  = 0; b2.din  = 0; b2.din_valid  = 0;

        // Reset values
        #2;
        check_val("rst_pattern", 32'(b10.pattern), 32'h0);
        check_val("rst_armed",   32'(b10.armed), 32'h0);
        check_val("rst_detect",  32'(b10.detect), 32'h0);
        check_val("rst_count",   32'(b10.match_count), 32'h0);
        tick();
        rst = 1'b0;

        // Load and single match
        load10(p1);
        check_val("load_pattern", 32'(b10.pattern), 32'h2ED);
        check_val("load_armed",   32'(b10.armed), 32'h1);
        for (int i = 9; i >= 0; i--) bit10(p1[i], i == 0, "single_det");
        tick();
        check_val("single_det_drop", 32'(b10.detect), 32'h0);
        check_val("single_count", 32'(b10.match_count), 32'd1);

        // Reload: old pattern no longer matches, new one does, count kept
        load10(p2);
        check_val("reload_pattern", 32'(b10.pattern), 32'h108);
        for (int i = 9; i >= 0; i--) bit10(p1[i], 1'b0, "reload_old_det");
        for (int i = 9; i >= 0; i--) bit10(p2[i], i == 0, "reload_new_det");
        check_val("reload_count", 32'(b10.match_count), 32'd2);

        // Stall: gaps with garbage din inside the stream
        load10(p1);
        for (int i = 9; i >= 0; i--) begin
            bit10(p1[i], i == 0, "stall_det");
            if (i != 0 && (i % 3) == 0) begin
                b10.din = ~p1[i-1];
                tick();
                check_val("stall_gap_det", 32'(b10.detect), 32'h0);
            end
        end
        tick();
        check_val("stall_after_det", 32'(b10.detect), 32'h0);
        check_val("stall_count", 32'(b10.match_count), 32'd3);

        // Collision: load on the 10th bit drops that bit
        load10(p1);
        for (int i = 9; i >= 1; i--) bit10(p1[i], 1'b0, "coll_pre_det");
        b10.din       = p1[0];
        b10.din_valid = 1'b1;
        b10.load      = 1'b1;
        tick();
        b10.load      = 1'b0;
        b10.din_valid = 1'b0;
        check_val("coll_det", 32'(b10.detect), 32'h0);
        check_val("coll_count", 32'(b10.match_count), 32'd3);
        for (int i = 9; i >= 0; i--) bit10(p1[i], i == 0, "coll_refill_det");
        check_val("coll_refill_count", 32'(b10.match_count), 32'd4);

        // Overlap vs non-overlap, 4-bit pattern 1010
        b4o.switches = 4'b1010; b4n.switches = 4'b1010;
        b4o.load = 1; b4n.load = 1;
        tick();
        b4o.load = 0; b4n.load = 0;
        for (int i = 0; i < 8; i++) begin
            b4o.din = s4[7-i]; b4n.din = s4[7-i];
            b4o.din_valid = 1; b4n.din_valid = 1;
            tick();
            b4o.din_valid = 0; b4n.din_valid = 0;
            check_val("ovl_det",   32'(b4o.detect), 32'(i == 3 || i == 5 || i == 7));
            check_val("noovl_det", 32'(b4n.detect), 32'(i == 3 || i == 7));
        end
        check_val("ovl_count",   32'(b4o.match_count), 32'd3);
        check_val("noovl_count", 32'(b4n.match_count), 32'd2);

        // All-zero pattern: cleared window is not history
        b4o.switches = 4'b0000; b4o.load = 1;
        tick();
        b4o.load = 0;
        for (int i = 0; i < 4; i++) begin
            b4o.din = 0; b4o.din_valid = 1;
            tick();
            b4o.din_valid = 0;
            check_val("zero_det", 32'(b4o.detect), 32'(i == 3));
        end
        check_val("zero_count", 32'(b4o.match_count), 32'd4);

        // Saturation: 2-bit counter holds at 3
        b2.switches = 2'b11; b2.load = 1;
        tick();
        b2.load = 0;
        for (int i = 0; i < 8; i++) begin
            b2.din = 1; b2.din_valid = 1;
            tick();
            b2.din_valid = 0;
            check_val("sat_det",   32'(b2.detect), 32'(i >= 1));
            check_val("sat_count", 32'(b2.match_count), 32'((i > 3) ? 3 : i));
        end
        tick();
        check_val("sat_idle_det", 32'(b2.detect), 32'h0);
        check_val("sat_hold",     32'(b2.match_count), 32'd3);

        // Async reset mid-cycle while detect is high
        load10(p1);
        for (int i = 9; i >= 0; i--) bit10(p1[i], i == 0, "pre_rst_det");
        #3;
        rst = 1'b1;
        #1;
        check_val("async_detect",  32'(b10.detect), 32'h0);
        check_val("async_count",   32'(b10.match_count), 32'h0);
        check_val("async_armed",   32'(b10.armed), 32'h0);
        check_val("async_pattern", 32'(b10.pattern), 32'h0);
        check_val("async_w2_count", 32'(b2.match_count), 32'h0);
        tick();
        rst = 1'b0;

        // No load after reset: ones are ignored
        for (int i = 0; i < 20; i++) bit10(1'b1, 1'b0, "noload_det");
        check_val("noload_count", 32'(b10.match_count), 32'h0);
        check_val("noload_armed", 32'(b10.armed), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sequence_capture_detector.md
# sequence_capture_detector

Parametrised sequence capture and serial detector for the sequence-detector design. On a `load` pulse it latches the `switches` bank into a WIDTH-bit pattern register. It then watches a qualified serial bit stream and pulses `detect` each time the last WIDTH accepted bits equal the stored pattern. It keeps a saturating match counter, and overlapping or non-overlapping detection is selectable at elaboration.

## Interface
- `WIDTH`, default 10: pattern length in bits; legal range 2..32.
- `COUNT_W`, default 8: width of `match_count`.
- `OVERLAP`, default 1:
  - 1: matches may share bits.
  - 0: history restarts after each match.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `switches`, input, WIDTH: pattern source; sampled only when `load`=1.
- `load`, input, 1: capture `switches` into `pattern` and re-arm.
- `din`, input, 1: serial data bit.
- `din_valid`, input, 1: `din` is accepted on an edge where this is 1.
- `pattern`, output, WIDTH: stored pattern.
- `armed`, output, 1: a pattern has been loaded since reset.
- `detect`, output, 1: single-cycle match pulse.
- `match_count`, output, COUNT_W: number of matches since reset; saturating.

## Operation
- **Reset values:** `pattern`=0, `armed`=0, `detect`=0, `match_count`=0. Internal state: shift window=0, fill counter=0, state IDLE.
- **Shift window:** on each accepted bit, the new bit enters at the LSB: window <= {window[WIDTH-2:0], din}. The first bit of a sequence therefore ends up in the MSB, and the pattern is compared MSB-first.
- **Fill counter:** counts accepted bits and saturates at WIDTH. Its width is clog2(WIDTH+1).
- **State machine:**
  - IDLE: no pattern loaded. Accepted bits are ignored; window and fill are not updated.
  - FILL: armed, with fill < WIDTH. Accepted bits shift in; no compare is made.
  - HUNT: armed, with fill == WIDTH. Every accepted bit triggers a compare.
  - IDLE -> FILL on `load`.
  - FILL -> HUNT when the accepted bit brings fill to WIDTH. That same bit is compared.
  - HUNT -> FILL on a match only when OVERLAP=0.
  - Any state -> FILL on `load`.
- **Load:** `pattern` <= `switches`, window <= 0, fill <= 0, `armed` <= 1. `match_count` is not cleared by `load`.
- **Match condition:** the next window value equals `pattern`, the bit is accepted, and the accepted bit makes fill reach or stay at WIDTH.
- **On a match:**
  - `detect` <= 1 for exactly one cycle.
  - `match_count` increments, saturating at 2^COUNT_W-1 (all ones; holds, no wrap).
  - If OVERLAP=0: fill <= 0. The window keeps shifting but is not compared until WIDTH new bits have been accepted.
- **Boundary conditions:**
  - `load` and `din_valid` on the same edge: `load` wins, and that `din` bit is discarded.
  - `din_valid`=0: window, fill, state and count hold; `detect` is 0 on the next cycle.
  - Pattern of all zeros: legal. It matches after WIDTH accepted zeros; the reset value of the window never counts as history.
  - `rst` asserted mid-stream: all state returns to reset values immediately, without waiting for a clock edge. The block stays in IDLE until the next `load`.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- **Detect latency:** the matching bit is accepted at edge k; `detect` is high from edge k to edge k+1. `match_count` shows the new value after edge k.
- **Back-to-back bits:** with OVERLAP=1 and `din_valid` high every cycle, `detect` may be high on consecutive cycles. An example is pattern all ones with a stream of ones.
- **Pattern capture:** after `load` at edge k, `pattern` and `armed` update at edge k. The earliest possible match is on the WIDTH-th accepted bit after edge k.
- **Reset release:** `rst` must deassert synchronously to `clk`; the reset synchroniser lives outside this block. The first `load` is accepted on the first edge after deassertion.

## Test plan
- **Reset:** assert `rst` mid-clock-cycle → all outputs 0 immediately, before the next edge. Then drive 20 accepted ones with no `load` → `detect` stays 0 and `match_count`=0.
- **Load and single match (WIDTH=10):**
  - Stimulus: `switches`=10'b1011101101, pulse `load`, then stream 1,0,1,1,1,0,1,1,0,1 with `din_valid`=1.
  - Required: `pattern`=10'h2ED and `armed`=1 after the load edge. `detect` is high for exactly the cycle after the 10th bit; `match_count`=1.
- **Overlap mode (WIDTH=4):**
  - OVERLAP=1, pattern 4'b1010, stream 1,0,1,0,1,0,1,0 → `detect` after bits 4, 6 and 8; `match_count`=3.
  - OVERLAP=0, same pattern and stream → `detect` after bits 4 and 8 only; `match_count`=2.
- **Stall and collision:**
  - Insert `din_valid`=0 gaps inside the pattern stream → the match is still detected, one cycle after the last valid bit.
  - Assert `load` on the same edge as the 10th bit → no `detect`; fill restarts at 0.
- **Reload:** after one match, load `switches`=10'b0100001000 and stream that pattern → `detect` fires for the new pattern only. `match_count`=2, because `load` does not clear it.
- **Saturation (COUNT_W=2):** WIDTH=2, OVERLAP=1, pattern 2'b11, stream of 8 ones → `detect` on 7 consecutive cycles; `match_count` reaches 3 and holds at 3.
